// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse transmitter: element encoding on the
// `elem` bus, FSM state enum, highest valid character code, and the packed
// layout of a pattern-ROM entry.
// ---------------------------------------------------------------------------
package morse_pkg;

  // Encoding of the 2-bit `elem` bus (also used by the press classifier).
  localparam logic [1:0] ELEM_WAIT = 2'b00;
  localparam logic [1:0] ELEM_DOT  = 2'b01;
  localparam logic [1:0] ELEM_DASH = 2'b10;
  localparam logic [1:0] ELEM_SEND = 2'b11;

  // Codes 0..25 are A..Z, 26..35 are digits 0..9; anything above is invalid.
  localparam int unsigned CODE_MAX = 35;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_CHAR_GAP
  } state_e;

  // Pattern bits are left-aligned: bits[4] is the first element sent,
  // 1 = dash, 0 = dot. Only the top `len` bits are meaningful.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] bits;
  } rom_entry_t;

endpackage

// File: rtl/morse_rom.sv
// ---------------------------------------------------------------------------
// morse_rom
// Combinational International Morse lookup.
//   char_code in  [5:0]  0-25 = A-Z, 26-35 = 0-9, 36-63 invalid
//   entry     out        {valid, len[2:0], bits[4:0]} (bits left-aligned)
// ---------------------------------------------------------------------------
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output rom_entry_t entry
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    entry = '0;
    case (char_code)
      6'd0:  entry = '{1'b1, 3'd2, 5'b01000}; // A .-
      6'd1:  entry = '{1'b1, 3'd4, 5'b10000}; // B -...
      6'd2:  entry = '{1'b1, 3'd4, 5'b10100}; // C -.-.
      6'd3:  entry = '{1'b1, 3'd3, 5'b10000}; // D -..
      6'd4:  entry = '{1'b1, 3'd1, 5'b00000}; // E .
      6'd5:  entry = '{1'b1, 3'd4, 5'b00100}; // F ..-.
      6'd6:  entry = '{1'b1, 3'd3, 5'b11000}; // G --.
      6'd7:  entry = '{1'b1, 3'd4, 5'b00000}; // H ....
      6'd8:  entry = '{1'b1, 3'd2, 5'b00000}; // I ..
      6'd9:  entry = '{1'b1, 3'd4, 5'b01110}; // J .---
      6'd10: entry = '{1'b1, 3'd3, 5'b10100}; // K -.-
      6'd11: entry = '{1'b1, 3'd4, 5'b01000}; // L .-..
      6'd12: entry = '{1'b1, 3'd2, 5'b11000}; // M --
      6'd13: entry = '{1'b1, 3'd2, 5'b10000}; // N -.
      6'd14: entry = '{1'b1, 3'd3, 5'b11100}; // O ---
      6'd15: entry = '{1'b1, 3'd4, 5'b01100}; // P .--.
      6'd16: entry = '{1'b1, 3'd4, 5'b11010}; // Q --.-
      6'd17: entry = '{1'b1, 3'd3, 5'b01000}; // R .-.
      6'd18: entry = '{1'b1, 3'd3, 5'b00000}; // S ...
      6'd19: entry = '{1'b1, 3'd1, 5'b10000}; // T -
      6'd20: entry = '{1'b1, 3'd3, 5'b00100}; // U ..-
      6'd21: entry = '{1'b1, 3'd4, 5'b00010}; // V ...-
      6'd22: entry = '{1'b1, 3'd3, 5'b01100}; // W .--
      6'd23: entry = '{1'b1, 3'd4, 5'b10010}; // X -..-
      6'd24: entry = '{1'b1, 3'd4, 5'b10110}; // Y -.--
      6'd25: entry = '{1'b1, 3'd4, 5'b11000}; // Z --..
      6'd26: entry = '{1'b1, 3'd5, 5'b11111}; // 0 -----
      6'd27: entry = '{1'b1, 3'd5, 5'b01111}; // 1 .----
      6'd28: entry = '{1'b1, 3'd5, 5'b00111}; // 2 ..---
      6'd29: entry = '{1'b1, 3'd5, 5'b00011}; // 3 ...--
      6'd30: entry = '{1'b1, 3'd5, 5'b00001}; // 4 ....-
      6'd31: entry = '{1'b1, 3'd5, 5'b00000}; // 5 .....
      6'd32: entry = '{1'b1, 3'd5, 5'b10000}; // 6 -....
      6'd33: entry = '{1'b1, 3'd5, 5'b11000}; // 7 --...
      6'd34: entry = '{1'b1, 3'd5, 5'b11100}; // 8 ---..
      6'd35: entry = '{1'b1, 3'd5, 5'b11110}; // 9 ----.
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// ---------------------------------------------------------------------------
// morse_tx
// Accepts one character code at a time and keys it out as Morse.
//   DOT_TICKS        clk cycles per dot unit (1..21845)
//   clk, rst_n       clock, asynchronous active-low reset
//   char_valid/code  upstream offer, code 0-25 A-Z, 26-35 0-9
//   char_ready  out  high only in IDLE
//   key_out     out  1 = mark
//   elem        out  00 wait, 01 dot, 10 dash, 11 last cycle of char gap
//   busy        out  state != IDLE
//   err         out  one-cycle pulse after an invalid code is accepted
// ---------------------------------------------------------------------------
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned DOT_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] elem,
  output logic       busy,
  output logic       err
);

  // Counter is loaded with duration-1 and expires at 0.
  localparam logic [15:0] DOT_LOAD  = 16'(DOT_TICKS - 1);
  localparam logic [15:0] DASH_LOAD = 16'(3 * DOT_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  pat_q, pat_d;   // remaining elements, current one in bit 4
  logic [2:0]  left_q, left_d; // elements remaining, including current
  logic        err_q, err_d;
  rom_entry_t  rom_entry;

  morse_rom u_rom (
    .char_code (char_code),
    .entry     (rom_entry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop, pattern included, is reset so a reset mid-character
    // leaves nothing that could resume; all state uses non-blocking '<='.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    left_d  = left_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (char_valid) begin
          if (rom_entry.valid) begin
            state_d = ST_MARK;
            pat_d   = rom_entry.bits;
            left_d  = rom_entry.len;
            cnt_d   = rom_entry.bits[4] ? DASH_LOAD : DOT_LOAD;
          end else begin
            // Invalid code is consumed; we stay in IDLE and flag it next cycle.
            err_d = 1'b1;
          end
        end
      end

      ST_MARK: begin
        if (cnt_q == '0) begin
          if (left_q == 3'd1) begin
            state_d = ST_CHAR_GAP;
            cnt_d   = DASH_LOAD;
            left_d  = '0;
            pat_d   = '0;
          end else begin
            state_d = ST_SPACE;
            cnt_d   = DOT_LOAD;
            pat_d   = {pat_q[3:0], 1'b0};
            left_d  = 3'(left_q - 3'd1);
          end
        end else begin
          cnt_d = 16'(cnt_q - 16'd1);
        end
      end

      ST_SPACE: begin
        if (cnt_q == '0) begin
          state_d = ST_MARK;
          cnt_d   = pat_q[4] ? DASH_LOAD : DOT_LOAD;
        end else begin
          cnt_d = 16'(cnt_q - 16'd1);
        end
      end

      ST_CHAR_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = 16'(cnt_q - 16'd1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so reset drops key_out
  // without waiting for a clock edge.
  always_comb begin
    char_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    key_out    = (state_q == ST_MARK);
    err        = err_q;
    elem       = ELEM_WAIT;
    if (state_q == ST_MARK) begin
      elem = pat_q[4] ? ELEM_DASH : ELEM_DOT;
    end else if (state_q == ST_CHAR_GAP && cnt_q == '0) begin
      elem = ELEM_SEND;
    end
  end

endmodule

// File: tb/tb_morse_tx.sv
// ---------------------------------------------------------------------------
// tb_morse_tx
// Two instances: dut0 with DOT_TICKS=4, dut1 with DOT_TICKS=1. Expected
// waveforms are built from textual Morse patterns (".-", "-..." ...).
// ---------------------------------------------------------------------------
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [5:0] c0 = '0, c1 = '0;
  logic       r0, k0, b0, e0, r1, k1, b1, e1;
  logic [1:0] el0, el1;

  int errors = 0;
  int checks = 0;

  string morse_tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  always #5 clk = ~clk;

  morse_tx #(.DOT_TICKS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .char_valid(v0), .char_code(c0),
    .char_ready(r0), .key_out(k0), .elem(el0), .busy(b0), .err(e0)
  );

  morse_tx #(.DOT_TICKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .char_valid(v1), .char_code(c1),
    .char_ready(r1), .key_out(k1), .elem(el1), .busy(b1), .err(e1)
  );

  task automatic drive(input int sel, input logic v, input logic [5:0] c);
    if (sel == 0) begin v0 = v; c0 = c; end
    else          begin v1 = v; c1 = c; end
  endtask

  // Returns {key, elem[1:0], busy, ready, err}
  function automatic logic [5:0] obs(input int sel);
    if (sel == 0) return {k0, el0, b0, r0, e0};
    else          return {k1, el1, b1, r1, e1};
  endfunction

  // Send one code and check every cycle until the block is ready again.
  task automatic run_char(input int sel, input int dot, input logic [5:0] code,
                          input bit hold, input string name);
    string      p;
    logic       exp_k [$];
    logic [1:0] exp_el [$];
    logic [5:0] o;
    logic [5:0] want;

    p = (code <= 6'd35) ? morse_tbl[code] : "";
    for (int i = 0; i < p.len(); i++) begin
      bit dash = (p[i] == "-");
      for (int t = 0; t < (dash ? 3 * dot : dot); t++) begin
        exp_k.push_back(1'b1);
        exp_el.push_back(dash ? 2'b10 : 2'b01);
      end
      if (i != p.len() - 1)
        for (int t = 0; t < dot; t++) begin exp_k.push_back(1'b0); exp_el.push_back(2'b00); end
    end
    if (p.len() != 0) begin
      for (int t = 0; t < 3 * dot - 1; t++) begin exp_k.push_back(1'b0); exp_el.push_back(2'b00); end
      exp_k.push_back(1'b0);
      exp_el.push_back(2'b11);
    end

    @(negedge clk);
    drive(sel, 1'b1, code);
    o = obs(sel);
    checks++;
    if (o[1] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, o[1]);
    end
    @(posedge clk);            // cycle 0: accept edge
    if (!hold) begin #1 drive(sel, 1'b0, 6'd0); end

    if (p.len() == 0) begin
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o !== 6'b0_00_011) begin
        errors++;
        $display("FAIL %s err_cycle1 {key,elem,busy,ready,err}: got %b want 000011", name, o);
      end
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o !== 6'b0_00_010) begin
        errors++;
        $display("FAIL %s err_cycle2 {key,elem,busy,ready,err}: got %b want 000010", name, o);
      end
    end else begin
      for (int n = 0; n < exp_k.size(); n++) begin
        @(negedge clk);
        o = obs(sel);
        want = {exp_k[n], exp_el[n], 1'b1, 1'b0, 1'b0};
        checks++;
        if (o !== want) begin
          errors++;
          $display("FAIL %s cycle%0d {key,elem,busy,ready,err}: got %b want %b",
                   name, n + 1, o, want);
        end
      end
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o !== 6'b0_00_010) begin
        errors++;
        $display("FAIL %s ready_cycle%0d {key,elem,busy,ready,err}: got %b want 000010",
                 name, exp_k.size() + 1, o);
      end
      if (hold) drive(sel, 1'b0, 6'd0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({k0, el0, b0, e0, k1, el1, b1, e1} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000000", {k0, el0, b0, e0, k1, el1, b1, e1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({r0, r1, b0, b1} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release_ready {r0,r1,b0,b1}: got %b want 1100", {r0, r1, b0, b1});
    end
  endtask

  task automatic test_letters;
    run_char(0, 4, 6'd4, 1'b0, "letter_E");
    run_char(0, 4, 6'd0, 1'b0, "letter_A");
  endtask

  task automatic test_digit_hold;
    run_char(0, 4, 6'd26, 1'b1, "digit0_hold");
  endtask

  task automatic test_invalid;
    run_char(0, 4, 6'd40, 1'b0, "invalid40");
    run_char(0, 4, 6'd36, 1'b0, "invalid36");
    run_char(0, 4, 6'd63, 1'b0, "invalid63");
  endtask

  task automatic test_reset_mid_char;
    @(negedge clk);
    drive(0, 1'b1, 6'd19);
    @(posedge clk);
    #1 drive(0, 1'b0, 6'd0);
    repeat (5) @(posedge clk);   // now inside cycle 6
    #2;
    checks++;
    if (k0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_key_before: got %b want 1", k0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({k0, el0, b0} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async {key,elem,busy}: got %b want 0000", {k0, el0, b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b want 1", r0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({k0, el0, b0} !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_residual cycle%0d {key,elem,busy}: got %b want 0000", i, {k0, el0, b0});
      end
    end
  endtask

  task automatic test_dot1;
    run_char(1, 1, 6'd18, 1'b0, "dot1_S");
    run_char(1, 1, 6'd19, 1'b0, "dot1_T");
    run_char(1, 1, 6'd40, 1'b0, "dot1_invalid");
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      logic [5:0] code;
      code = 6'($urandom_range(0, 63));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_char(i % 2, (i % 2 == 0) ? 4 : 1, code, 1'b0, $sformatf("random_%0d_code%0d", i, code));
    end
  endtask

  task automatic test_back_to_back;
    run_char(1, 1, 6'd35, 1'b0, "b2b_9");
    run_char(1, 1, 6'd0, 1'b0, "b2b_A");
    run_char(0, 4, 6'd16, 1'b0, "b2b_Q");
  endtask

  initial begin
    test_reset;
    test_letters;
    test_digit_hold;
    test_invalid;
    test_reset_mid_char;
    test_dot1;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
